instr_fetch: RTL and testbench

Instruction fetch front-end for the 16-bit CPU. Owns the program counter, issues reads to instruction memory over a req/ack handshake, and buffers fetched words in a small prefetch FIFO. Presents the oldest word, with its 4-bit opcode field split out, to the datapath/control-unit pair that decodes it. Flushes and redirects on a taken branch.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: field widths, opcode position,
// fetch FSM state encoding and PC arithmetic helpers.
package cpu_pkg;

    localparam int INSTR_W    = 16;
    localparam int ADDR_W     = 16;
    localparam int OPCODE_W   = 4;
    localparam int OPCODE_LSB = 12;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_FULL = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    // Sequential fetch address: one 16-bit word further, wrapping at 2^16.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(2);
    endfunction

    // Branch targets are word aligned; the byte-select bit is discarded.
    function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
        return {t[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {word, pc} pairs. Clear discards all entries and
// takes priority over a push or pop in the same cycle. Storage is reset so
// the head outputs never show X, even when the FIFO is empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clear,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_word,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    output logic [INSTR_W-1:0] head_word,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] word_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    assign head_word = word_q[rd_ptr];
    assign head_pc   = pc_q[rd_ptr];

    // Entry storage: written at the tail, cleared to zero on reset only.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (do_push && !clear) begin
            word_q[wr_ptr] <= push_word;
            pc_q[wr_ptr]   <= push_pc;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: owns the PC, runs the single-outstanding
// req/ack read to instruction memory, buffers words in fetch_fifo and
// redirects on a taken branch. A request already on the bus when a branch
// arrives is completed in S_DROP and its data thrown away.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] drop_addr;
    logic [ADDR_W-1:0] drop_addr_nxt;
    logic              fifo_push;
    logic              fifo_clear;
    logic              fifo_pop;
    logic [CNT_W-1:0]  count;

    assign fifo_pop    = instr_valid && instr_ready;
    assign instr_valid = (count != '0);
    assign opcode      = instr[OPCODE_LSB +: OPCODE_W];

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_word (imem_rdata),
        .push_pc   (pc),
        .pop       (fifo_pop),
        .head_word (instr),
        .head_pc   (instr_pc),
        .count     (count)
    );

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // PC and the address of a request being drained after a redirect.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc        <= RESET_PC;
            drop_addr <= '0;
        end else begin
            pc        <= pc_nxt;
            drop_addr <= drop_addr_nxt;
        end
    end

    // Next state, PC update, FIFO control and memory request outputs.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_addr_nxt = drop_addr;
        fifo_push     = 1'b0;
        fifo_clear    = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pc;

        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    // Redirect: any data returning now or later for the old pc is stale.
                    fifo_clear    = 1'b1;
                    pc_nxt        = align_target(branch_target);
                    drop_addr_nxt = pc;
                    state_nxt     = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack) begin
                    fifo_push = 1'b1;
                    pc_nxt    = pc_inc(pc);
                    // Keep requesting only if there is still room after this push/pop.
                    if ((int'(count) + 1 - int'(fifo_pop)) < DEPTH) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (branch_taken) begin
                    fifo_clear = 1'b1;
                    pc_nxt     = align_target(branch_target);
                    state_nxt  = S_REQ;
                end else if (int'(count) < DEPTH) begin
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                // Hold the abandoned address stable until memory completes it.
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (branch_taken) begin
                    fifo_clear = 1'b1;
                    pc_nxt     = align_target(branch_target);
                end
                if (imem_ack) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // Reset withdraws the request immediately so memory abandons the access.
        if (Reset) begin
            imem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Instance u_dut: DEPTH=2, RESET_PC=0 with a
// memory of configurable wait cycles. Instance u_dut2: DEPTH=4,
// RESET_PC=FFFC with a zero-wait memory. Both memories return addr ^ C000.
module tb_instr_fetch;

    logic        Clock;
    logic        Reset;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic        req2;
    logic [15:0] addr2;
    logic        ack2;
    logic [15:0] rdata2;
    logic        valid2;
    logic [15:0] instr2;
    logic [3:0]  opcode2;
    logic [15:0] pc2;
    logic        ready2;
    logic        br2;
    logic [15:0] tgt2;

    int total;
    int bad;
    int wait_cfg;
    int wcnt;

    instr_fetch #(.DEPTH(2), .RESET_PC(16'h0000)) u_dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .opcode        (opcode),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    instr_fetch #(.DEPTH(4), .RESET_PC(16'hFFFC)) u_dut2 (
        .Clock         (Clock),
        .Reset         (Reset),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ack      (ack2),
        .imem_rdata    (rdata2),
        .instr_valid   (valid2),
        .instr         (instr2),
        .opcode        (opcode2),
        .instr_pc      (pc2),
        .instr_ready   (ready2),
        .branch_taken  (br2),
        .branch_target (tgt2)
    );

    // Memory models
    assign imem_ack   = imem_req && (wcnt >= wait_cfg);
    assign imem_rdata = imem_addr ^ 16'hC000;
    assign ack2       = req2;
    assign rdata2     = addr2 ^ 16'hC000;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_opcode", {12'd0, opcode}, 16'd0);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_req2", {15'd0, req2}, 16'd0);
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        wait_cfg = 0;
        Reset = 1'b1;
        instr_ready = 1'b1;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        ready2 = 1'b1;
        br2 = 1'b0;
        tgt2 = 16'h0000;

        // Streaming with zero-wait memory; second instance wraps from FFFC
        do_reset();
        chk("s_c1_req", {15'd0, imem_req}, 16'd1);
        chk("s_c1_addr", imem_addr, 16'h0000);
        chk("s_c1_valid", {15'd0, instr_valid}, 16'd0);
        chk("w_c1_addr", addr2, 16'hFFFC);
        tick();
        chk("s_c2_addr", imem_addr, 16'h0002);
        chk("s_c2_valid", {15'd0, instr_valid}, 16'd1);
        chk("s_c2_pc", instr_pc, 16'h0000);
        chk("s_c2_instr", instr, 16'hC000);
        chk("s_c2_opc", {12'd0, opcode}, 16'h000C);
        chk("w_c2_addr", addr2, 16'hFFFE);
        chk("w_c2_pc", pc2, 16'hFFFC);
        chk("w_c2_opc", {12'd0, opcode2}, 16'h0003);
        tick();
        chk("s_c3_addr", imem_addr, 16'h0004);
        chk("s_c3_pc", instr_pc, 16'h0002);
        chk("s_c3_instr", instr, 16'hC002);
        chk("w_c3_addr", addr2, 16'h0000);
        chk("w_c3_pc", pc2, 16'hFFFE);
        tick();
        chk("s_c4_pc", instr_pc, 16'h0004);
        chk("w_c4_pc", pc2, 16'h0000);
        chk("w_c4_instr", instr2, 16'hC000);

        // Backpressure: fill to DEPTH, stall, then drain in order
        instr_ready = 1'b0;
        do_reset();
        chk("f_c1_addr", imem_addr, 16'h0000);
        tick();
        chk("f_c2_req", {15'd0, imem_req}, 16'd1);
        chk("f_c2_addr", imem_addr, 16'h0002);
        tick();
        chk("f_c3_req", {15'd0, imem_req}, 16'd0);
        chk("f_c3_pc", instr_pc, 16'h0000);
        tick();
        chk("f_c4_req", {15'd0, imem_req}, 16'd0);
        chk("f_c4_pc", instr_pc, 16'h0000);
        instr_ready = 1'b1;
        tick();
        chk("f_c5_req", {15'd0, imem_req}, 16'd0);
        chk("f_c5_valid", {15'd0, instr_valid}, 16'd1);
        chk("f_c5_pc", instr_pc, 16'h0002);
        chk("f_c5_instr", instr, 16'hC002);
        tick();
        chk("f_c6_req", {15'd0, imem_req}, 16'd1);
        chk("f_c6_addr", imem_addr, 16'h0004);
        chk("f_c6_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("f_c7_pc", instr_pc, 16'h0004);

        // 3-wait memory, branch two cycles into the request for 0002
        wait_cfg = 3;
        do_reset();
        tick();
        tick();
        tick();
        chk("d_c4_ack", {15'd0, imem_ack}, 16'd1);
        tick();
        chk("d_c5_addr", imem_addr, 16'h0002);
        chk("d_c5_pc", instr_pc, 16'h0000);
        chk("d_c5_ack", {15'd0, imem_ack}, 16'd0);
        tick();
        chk("d_c6_addr", imem_addr, 16'h0002);
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        chk("d_c7_req", {15'd0, imem_req}, 16'd1);
        chk("d_c7_addr", imem_addr, 16'h0002);
        chk("d_c7_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("d_c8_addr", imem_addr, 16'h0002);
        chk("d_c8_ack", {15'd0, imem_ack}, 16'd1);
        tick();
        chk("d_c9_addr", imem_addr, 16'h0040);
        chk("d_c9_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        tick();
        tick();
        chk("d_c12_ack", {15'd0, imem_ack}, 16'd1);
        chk("d_c12_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("d_c13_valid", {15'd0, instr_valid}, 16'd1);
        chk("d_c13_pc", instr_pc, 16'h0040);
        chk("d_c13_instr", instr, 16'hC040);

        // Branch coinciding with ack and pop; odd target is aligned
        wait_cfg = 0;
        instr_ready = 1'b0;
        do_reset();
        tick();
        chk("a_c2_pc", instr_pc, 16'h0000);
        chk("a_c2_ack", {15'd0, imem_ack}, 16'd1);
        instr_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 16'h0021;
        tick();
        branch_taken = 1'b0;
        chk("a_c3_valid", {15'd0, instr_valid}, 16'd0);
        chk("a_c3_addr", imem_addr, 16'h0020);
        tick();
        chk("a_c4_valid", {15'd0, instr_valid}, 16'd1);
        chk("a_c4_pc", instr_pc, 16'h0020);
        chk("a_c4_instr", instr, 16'hC020);
        tick();
        chk("a_c5_pc", instr_pc, 16'h0022);

        // Branch with a full FIFO (S_FULL) and a pop in the same cycle
        instr_ready = 1'b0;
        do_reset();
        tick();
        tick();
        chk("b_c3_req", {15'd0, imem_req}, 16'd0);
        instr_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 16'h0080;
        tick();
        branch_taken = 1'b0;
        chk("b_c4_valid", {15'd0, instr_valid}, 16'd0);
        chk("b_c4_req", {15'd0, imem_req}, 16'd1);
        chk("b_c4_addr", imem_addr, 16'h0080);
        tick();
        chk("b_c5_pc", instr_pc, 16'h0080);

        // Asynchronous reset mid-request with two entries buffered (DEPTH=4)
        ready2 = 1'b0;
        do_reset();
        chk("r_c1_addr2", addr2, 16'hFFFC);
        tick();
        chk("r_c2_pc2", pc2, 16'hFFFC);
        tick();
        chk("r_c3_req2", {15'd0, req2}, 16'd1);
        chk("r_c3_addr2", addr2, 16'h0000);
        chk("r_c3_valid2", {15'd0, valid2}, 16'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("r_async_req2", {15'd0, req2}, 16'd0);
        chk("r_async_valid2", {15'd0, valid2}, 16'd0);
        chk("r_async_pc2", pc2, 16'h0000);
        chk("r_async_instr2", instr2, 16'h0000);
        chk("r_async_req", {15'd0, imem_req}, 16'd0);
        tick();
        Reset = 1'b0;
        #1;
        chk("r_rst_req2", {15'd0, req2}, 16'd1);
        chk("r_rst_addr2", addr2, 16'hFFFC);
        chk("r_rst_valid2", {15'd0, valid2}, 16'd0);
        chk("r_rst_addr", imem_addr, 16'h0000);
        tick();
        chk("r_rst_pc2", pc2, 16'hFFFC);
        chk("r_rst_addr2b", addr2, 16'hFFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
